// File: rtl/tinker_prog_loader_if.sv
// Instruction word stream in, 64-bit memory write port out.
// master = program source side, slave = loader side.
interface tinker_prog_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );
endinterface

// File: rtl/tinker_prog_loader.sv
// Packs 32-bit words in pairs into 64-bit writes from BASE_ADDR; holds core.
// Optional running checksum check: define LOADER_CHECKSUM_EN.
module tinker_prog_loader #(
   parameter logic [63:0] BASE_ADDR  = 64'h2000,
   parameter logic [63:0] LIMIT_ADDR = 64'd524288,
   parameter int          CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef LOADER_CHECKSUM_EN
   input  logic [31:0]      expected_sum,
`endif
   tinker_prog_loader_if.slave bus,
   output logic             core_hold,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] word_count,
   output logic [31:0]      checksum
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL_LO,
      S_FILL_HI,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [63:0]      addr_q, addr_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      hi_q, hi_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [64:0]      end_addr;
   logic             over;
   logic             sum_bad;
   logic             xfer;
   logic             mem_we;

`ifdef LOADER_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;
   assign checksum = sum_q;
   assign sum_bad  = (sum_q != expected_sum);
`else
   assign checksum = '0;
   assign sum_bad  = 1'b0;
`endif

   assign bus.in_ready  = (state_q == S_FILL_LO) ||
                          (state_q == S_FILL_HI);
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = {hi_q, lo_q};
   assign core_hold     = (state_q != S_DONE);
   assign done          = (state_q == S_DONE);
   assign error         = (state_q == S_ERROR);
   assign word_count    = cnt_q;

   assign xfer     = bus.in_valid && bus.in_ready;
   assign cnt_inc  = (cnt_q == '1) ? cnt_q
                   : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   // 65-bit sum so a write near the top of the space cannot wrap
   assign end_addr = {1'b0, addr_q} + 65'd8;
   assign over     = end_addr > {1'b0, LIMIT_ADDR};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = sum_q;
      if (xfer) sum_d = sum_q + bus.in_data;
`endif
      mem_we  = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_FILL_LO;
               addr_d  = BASE_ADDR;
               cnt_d   = '0;
               last_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         S_FILL_LO: begin
            if (xfer) begin
               lo_d  = bus.in_data;
               cnt_d = cnt_inc;
               if (bus.in_last) begin
                  hi_d    = '0;
                  last_d  = 1'b1;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_FILL_HI;
               end
            end
         end
         S_FILL_HI: begin
            if (xfer) begin
               hi_d    = bus.in_data;
               cnt_d   = cnt_inc;
               last_d  = bus.in_last;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (over) begin
               state_d = S_ERROR;
            end else begin
               mem_we = 1'b1;
               addr_d = addr_q + 64'd8;
               if (!last_q)     state_d = S_FILL_LO;
               else if (sum_bad) state_d = S_ERROR;
               else              state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         addr_q  <= BASE_ADDR;
         lo_q    <= '0;
         hi_q    <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

endmodule

// File: tb/tb_tinker_prog_loader.sv
// Directed bench for tinker_prog_loader: table of loads plus corner sequences.
// A second instance with a tight LIMIT_ADDR shares the stimulus.
module tb_tinker_prog_loader;

   localparam logic [63:0] BASE = 64'h2000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] expected_sum;
   logic        core_hold, done, error;
   logic [15:0] word_count;
   logic [31:0] checksum;
   logic        l_hold, l_done, l_error;
   logic [15:0] l_count;
   logic [31:0] l_sum;

   int passed = 0;
   int total  = 0;

   tinker_prog_loader_if bus ();
   tinker_prog_loader_if bus2 ();

   assign bus2.in_valid = bus.in_valid;
   assign bus2.in_data  = bus.in_data;
   assign bus2.in_last  = bus.in_last;

   always #5 clk = ~clk;

   tinker_prog_loader dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
`ifdef LOADER_CHECKSUM_EN
      .expected_sum(expected_sum),
`endif
      .bus         (bus),
      .core_hold   (core_hold),
      .done        (done),
      .error       (error),
      .word_count  (word_count),
      .checksum    (checksum)
   );

   tinker_prog_loader #(.LIMIT_ADDR(64'h2008)) dut_lim (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
`ifdef LOADER_CHECKSUM_EN
      .expected_sum(expected_sum),
`endif
      .bus         (bus2),
      .core_hold   (l_hold),
      .done        (l_done),
      .error       (l_error),
      .word_count  (l_count),
      .checksum    (l_sum)
   );

   logic [127:0] wq[$];
   logic [127:0] wq2[$];
   logic         we_prev   = 1'b0;
   int           pulse_bad = 0;

   always @(negedge clk) begin
      if (bus.mem_we) wq.push_back({bus.mem_addr, bus.mem_wdata});
      if (bus2.mem_we) wq2.push_back({bus2.mem_addr, bus2.mem_wdata});
      if (bus.mem_we && we_prev) pulse_bad <= pulse_bad + 1;
      we_prev <= bus.mem_we;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      else
         passed++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic last,
                       input int gap);
      bit ok;
      repeat (gap) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bus.in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("handshake", {63'd0, ok}, 64'd1);
   endtask

   task automatic wait_end();
      for (int k = 0; k < 10; k++) begin
         if (done || error) break;
         @(posedge clk); #1;
      end
      chk("end_timeout", {63'd0, done | error}, 64'd1);
   endtask

   typedef struct {
      int              n;
      logic [3:0][31:0] w;
      int              gap;
      int              nwr;
      logic [1:0][63:0] wa;
      logic [1:0][63:0] wd;
   } vec_t;

   vec_t vt[5];

   task automatic run_load(input vec_t v, input string nm);
      logic [31:0]  s;
      logic [127:0] e;
      s = '0;
      for (int i = 0; i < v.n; i++) s = s + v.w[i];
      expected_sum = s;
      wq.delete();
      wq2.delete();
      pulse_start();
      for (int i = 0; i < v.n; i++)
         send(v.w[i], (i == v.n - 1), v.gap);
      wait_end();
      chk({nm, "_nwr"}, 64'(wq.size()), 64'(v.nwr));
      for (int i = 0; i < v.nwr; i++) begin
         e = (i < wq.size()) ? wq[i] : '0;
         chk({nm, "_addr"}, e[127:64], v.wa[i]);
         chk({nm, "_data"}, e[63:0], v.wd[i]);
      end
      chk({nm, "_count"}, 64'(word_count), 64'(v.n));
      chk({nm, "_done"}, {63'd0, done}, 64'd1);
      chk({nm, "_err"}, {63'd0, error}, 64'd0);
      chk({nm, "_hold"}, {63'd0, core_hold}, 64'd0);
`ifdef LOADER_CHECKSUM_EN
      chk({nm, "_sum"}, 64'(checksum), 64'(s));
`else
      chk({nm, "_sum"}, 64'(checksum), 64'd0);
`endif
      chk({nm, "_pulse"}, 64'(pulse_bad), 64'd0);
   endtask

   initial begin
      logic [127:0] e;
      vt[0] = '{2, {32'h0, 32'h0, 32'h00000002, 32'hC8000001}, 0, 1,
                {64'h0, BASE}, {64'h0, 64'h00000002_C8000001}};
      vt[1] = '{3, {32'h0, 32'h33333333, 32'h22222222, 32'h11111111},
                0, 2, {BASE + 64'd8, BASE},
                {64'h00000000_33333333, 64'h22222222_11111111}};
      vt[2] = '{4, {32'h0BADF00D, 32'h89ABCDEF, 32'h01234567,
                32'hDEADBEEF}, 0, 2, {BASE + 64'd8, BASE},
                {64'h0BADF00D_89ABCDEF, 64'h01234567_DEADBEEF}};
      vt[3] = vt[2];
      vt[3].gap = 1;
      vt[4] = '{1, {32'h0, 32'h0, 32'h0, 32'h000000FF}, 0, 1,
                {64'h0, BASE}, {64'h0, 64'h00000000_000000FF}};

      reset        = 1'b0;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      expected_sum = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold", {63'd0, core_hold}, 64'd1);
      chk("rst_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("rst_we", {63'd0, bus.mem_we}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_err", {63'd0, error}, 64'd0);
      chk("rst_addr", bus.mem_addr, BASE);
      chk("rst_wdata", bus.mem_wdata, 64'd0);
      chk("rst_count", 64'(word_count), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("idle_hold", {63'd0, core_hold}, 64'd1);
      chk("idle_ready", {63'd0, bus.in_ready}, 64'd0);

      for (int i = 0; i < 5; i++) run_load(vt[i], $sformatf("vec%0d", i));

      // limit instance: first pair fits, second would cross 0x2008
      chk("lim_nwr", 64'(wq2.size()), 64'd1);
      e = (wq2.size() > 0) ? wq2[0] : '0;
      chk("lim_addr", e[127:64], BASE);
      chk("lim_data", e[63:0], 64'h00000000_000000FF);
      run_load(vt[2], "limdut");
      chk("lim_nwr4", 64'(wq2.size()), 64'd1);
      e = (wq2.size() > 0) ? wq2[0] : '0;
      chk("lim_addr4", e[127:64], BASE);
      chk("lim_data4", e[63:0], 64'h01234567_DEADBEEF);
      chk("lim_err", {63'd0, l_error}, 64'd1);
      chk("lim_hold", {63'd0, l_hold}, 64'd1);
      chk("lim_done", {63'd0, l_done}, 64'd0);

      // single-cycle latency from second word to mem_we
      expected_sum = 32'hA0A0A0A0 + 32'h0B0B0B0B;
      wq.delete();
      pulse_start();
      chk("lim_err_clr", {63'd0, l_error}, 64'd0);
      chk("restart_hold", {63'd0, core_hold}, 64'd1);
      chk("restart_cnt", 64'(word_count), 64'd0);
      send(32'hA0A0A0A0, 1'b0, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0B0B0B0B;
      bus.in_last  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("lat_we", {63'd0, bus.mem_we}, 64'd1);
      chk("lat_addr", bus.mem_addr, BASE);
      chk("lat_data", bus.mem_wdata, 64'h0B0B0B0B_A0A0A0A0);
      chk("lat_ready", {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk); #1;
      chk("lat_we_off", {63'd0, bus.mem_we}, 64'd0);
      chk("lat_done", {63'd0, done}, 64'd1);

      // start mid-load is ignored
      expected_sum = 32'h5 + 32'h6;
      wq.delete();
      pulse_start();
      send(32'h5, 1'b0, 0);
      pulse_start();
      send(32'h6, 1'b1, 0);
      wait_end();
      chk("ign_count", 64'(word_count), 64'd2);
      chk("ign_nwr", 64'(wq.size()), 64'd1);
      e = (wq.size() > 0) ? wq[0] : '0;
      chk("ign_data", e[63:0], 64'h00000006_00000005);
      chk("ign_done", {63'd0, done}, 64'd1);

      // async reset while in FILL_HI
      pulse_start();
      send(32'h77, 1'b0, 0);
      chk("fh_ready", {63'd0, bus.in_ready}, 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("ar_hold", {63'd0, core_hold}, 64'd1);
      chk("ar_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("ar_count", 64'(word_count), 64'd0);
      chk("ar_addr", bus.mem_addr, BASE);
      chk("ar_wdata", bus.mem_wdata, 64'd0);
      chk("ar_done", {63'd0, done}, 64'd0);
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #1;

`ifdef LOADER_CHECKSUM_EN
      expected_sum = 32'd4;
      wq.delete();
      pulse_start();
      send(32'd1, 1'b0, 0);
      send(32'd2, 1'b1, 0);
      wait_end();
      chk("cs_nwr", 64'(wq.size()), 64'd1);
      e = (wq.size() > 0) ? wq[0] : '0;
      chk("cs_data", e[63:0], 64'h00000002_00000001);
      chk("cs_err", {63'd0, error}, 64'd1);
      chk("cs_done", {63'd0, done}, 64'd0);
      chk("cs_sum", 64'(checksum), 64'd3);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
